uart_tx_serializer: RTL and testbench

//  Downstream stage of the UART TX FIFO. Pops bytes from the FIFO with the next_frame request and

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx_serializer.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor and parity helpers.
// The TX serializer uses this package, and the RX deserializer is meant to reuse it.
package uart_pkg;

    localparam int unsigned STATE_W       = 3;
    localparam int unsigned BIT_CNT_W     = 3;
    localparam int unsigned MAX_DATA_BITS = 8;

    // Frame sequencing states. The explicit encoding keeps debug dumps stable.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } uart_state_t;

    // Clocks per bit (integer divide); the caller must guarantee a result >= 2.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Parity over the low nbits of data. Even parity returns the XOR of those
    // bits. Odd parity returns its complement.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int                      nbits,
                                        input logic                    odd);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < int'(MAX_DATA_BITS); i++) begin
            if (i < nbits) begin
                acc = acc ^ data[i];
            end
        end
        return acc ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer. It counts 0..CLKS_PER_BIT-1 and wraps at every bit boundary.
// bit_tick marks the last cycle of a bit period. pre_tick marks the cycle before it,
// which lets the caller register a pulse that must line up with the last cycle.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_reg;

    // Free-running modulo counter. While the line is not framing, clear holds it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear || (cnt_reg == LAST_CNT)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bit_tick = (cnt_reg == LAST_CNT);
    assign pre_tick = (cnt_reg == PRE_CNT);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer. It pops bytes from the TX FIFO and sends each one as:
// a start bit, DATA_BITS data bits (LSB first), an optional parity bit, and STOP_BITS
// stop bits. Every output is registered. A frame that has started always completes,
// unless reset is asserted.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115_200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned PARITY_ODD  = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic       clk_uart_tx,
    input  logic       rst_n,
    input  logic       tx_enable,
    input  logic       fifo_empty,
    input  logic [7:0] data_in,
    output logic       next_frame,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_IDX = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP_IDX = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic                 PAR_ODD       = (PARITY_ODD != 0);
    localparam bit                   HAS_PARITY    = (PARITY_EN != 0);

    uart_state_t          state_reg,      state_next;
    logic [7:0]           shift_reg,      shift_next;
    logic [BIT_CNT_W-1:0] bit_cnt_reg,    bit_cnt_next;
    logic                 parity_reg,     parity_next;
    logic                 tx_serial_reg,  tx_serial_next;
    logic                 next_frame_reg, next_frame_next;
    logic                 tx_busy_reg,    tx_busy_next;
    logic                 tx_done_reg,    tx_done_next;

    logic bit_tick;
    logic pre_tick;
    logic baud_clear;
    logic start_req;

    // The baud timer runs only while a bit is on the line. The WAIT->START
    // transition therefore always begins a full start-bit period.
    assign baud_clear = (state_reg == S_IDLE) || (state_reg == S_FETCH) ||
                        (state_reg == S_WAIT);

    // The FIFO handshake inputs matter only in IDLE and on the last stop cycle.
    assign start_req = tx_enable && !fifo_empty;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk_uart_tx),
        .rst_n    (rst_n),
        .clear    (baud_clear),
        .bit_tick (bit_tick),
        .pre_tick (pre_tick)
    );

    // State and output registers. Asynchronous reset drives the line high at once.
    always_ff @(posedge clk_uart_tx or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            parity_reg     <= 1'b0;
            tx_serial_reg  <= 1'b1;
            next_frame_reg <= 1'b0;
            tx_busy_reg    <= 1'b0;
            tx_done_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            parity_reg     <= parity_next;
            tx_serial_reg  <= tx_serial_next;
            next_frame_reg <= next_frame_next;
            tx_busy_reg    <= tx_busy_next;
            tx_done_reg    <= tx_done_next;
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        parity_next     = parity_reg;
        tx_serial_next  = tx_serial_reg;
        next_frame_next = 1'b0;
        tx_busy_next    = tx_busy_reg;
        tx_done_next    = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                tx_serial_next = 1'b1;
                tx_busy_next   = 1'b0;
                if (start_req) begin
                    next_frame_next = 1'b1;
                    tx_busy_next    = 1'b1;
                    state_next      = S_FETCH;
                end
            end

            // The FIFO sees the pop during this cycle. Its read data is valid in WAIT.
            S_FETCH: begin
                state_next = S_WAIT;
            end

            // Capture the byte and its parity together. Later changes on data_in
            // cannot affect this frame.
            S_WAIT: begin
                shift_next     = data_in;
                parity_next    = parity_bit(data_in, int'(DATA_BITS), PAR_ODD);
                tx_serial_next = 1'b0;
                bit_cnt_next   = '0;
                state_next     = S_START;
            end

            S_START: begin
                if (bit_tick) begin
                    tx_serial_next = shift_reg[0];
                    shift_next     = {1'b0, shift_reg[7:1]};
                    bit_cnt_next   = '0;
                    state_next     = S_DATA;
                end
            end

            // bit_cnt_reg holds the index of the data bit now on the line.
            S_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_reg == LAST_DATA_IDX) begin
                        bit_cnt_next = '0;
                        if (HAS_PARITY) begin
                            tx_serial_next = parity_reg;
                            state_next     = S_PARITY;
                        end else begin
                            tx_serial_next = 1'b1;
                            state_next     = S_STOP;
                        end
                    end else begin
                        tx_serial_next = shift_reg[0];
                        shift_next     = {1'b0, shift_reg[7:1]};
                        bit_cnt_next   = bit_cnt_reg + 1'b1;
                    end
                end
            end

            S_PARITY: begin
                if (bit_tick) begin
                    tx_serial_next = 1'b1;
                    bit_cnt_next   = '0;
                    state_next     = S_STOP;
                end
            end

            // bit_cnt_reg counts stop bits. tx_done is registered one cycle early,
            // so its pulse covers exactly the final stop cycle.
            S_STOP: begin
                tx_serial_next = 1'b1;
                if (pre_tick && (bit_cnt_reg == LAST_STOP_IDX)) begin
                    tx_done_next = 1'b1;
                end
                if (bit_tick) begin
                    if (bit_cnt_reg == LAST_STOP_IDX) begin
                        bit_cnt_next = '0;
                        if (start_req) begin
                            next_frame_next = 1'b1;
                            state_next      = S_FETCH;
                        end else begin
                            tx_busy_next = 1'b0;
                            state_next   = S_IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                tx_serial_next = 1'b1;
                tx_busy_next   = 1'b0;
                state_next     = S_IDLE;
            end
        endcase
    end

    assign next_frame = next_frame_reg;
    assign tx_serial  = tx_serial_reg;
    assign tx_busy    = tx_busy_reg;
    assign tx_done    = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer. It runs three parameter sets side by side:
//   8N1, 7 data bits with odd parity and 2 stop bits, and 8 data bits with even parity.
// For each set, a FIFO model feeds bytes. When a pop is seen, the expected byte goes
// into a scoreboard queue. A monitor pops that queue when a start bit appears and
// checks the line, cycle by cycle, against a frame built from the framing rules.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    localparam int CPB   = 10;
    localparam int N_DUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference frame: the line level of each bit slot, one bit per slot, LSB = start bit.
    function automatic int frame_bits(input int b, input int db, input int pen,
                                      input int podd, input int sb);
        int payload;
        int v;
        int n;
        payload = b % (1 << db);
        v = 0;
        n = 1;
        for (int i = 0; i < db; i++) begin
            v = v | (((payload >> i) & 1) << n);
            n++;
        end
        if (pen != 0) begin
            v = v | ((($countones(payload) % 2) ^ podd) << n);
            n++;
        end
        for (int s = 0; s < sb; s++) begin
            v = v | (1 << n);
            n++;
        end
        return v;
    endfunction

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g
        localparam int DB   = (gi == 1) ? 7 : 8;
        localparam int PEN  = (gi == 0) ? 0 : 1;
        localparam int PODD = (gi == 1) ? 1 : 0;
        localparam int SB   = (gi == 1) ? 2 : 1;
        localparam int FLEN = 1 + DB + PEN + SB;

        logic       rst_n      = 1'b0;
        logic       tx_enable  = 1'b0;
        logic       fifo_empty = 1'b1;
        logic [7:0] data_in    = 8'h00;
        logic       next_frame;
        logic       tx_serial;
        logic       tx_busy;
        logic       tx_done;

        byte unsigned fifo_q[$];
        int           exp_q[$];
        bit en_req    = 1'b0;
        bit done_flag = 1'b0;
        bit in_frame  = 1'b0;
        bit mdl_idle  = 1'b1;
        bit prev_rstn = 1'b0;
        bit prev_req  = 1'b0;
        bit exp_done  = 1'b0;
        int cyc = 0, nf_cyc = -100, end_cyc = -100, pos = 0, fb = 0;
        int cur = 0, stage = 0, bad_pos = -1, fbyte = 0, n_rand = 0;

        uart_tx_serializer #(
            .CLK_FREQ_HZ (1_000_000),
            .BAUD_RATE   (100_000),
            .DATA_BITS   (DB),
            .PARITY_EN   (PEN),
            .PARITY_ODD  (PODD),
            .STOP_BITS   (SB)
        ) dut (
            .clk_uart_tx (clk),
            .rst_n       (rst_n),
            .tx_enable   (tx_enable),
            .fifo_empty  (fifo_empty),
            .data_in     (data_in),
            .next_frame  (next_frame),
            .tx_serial   (tx_serial),
            .tx_busy     (tx_busy),
            .tx_done     (tx_done)
        );

        // Monitor, scoreboard and FIFO model, all evaluated at the falling edge.
        always @(negedge clk) begin
            if (!rst_n) begin
                in_frame = 1'b0;
                mdl_idle = 1'b1;
                stage    = 0;
                exp_q.delete();
            end else begin
                chk($sformatf("cfg%0d next_frame", gi), int'(next_frame),
                    int'(prev_rstn && prev_req && mdl_idle));
                if (next_frame) begin
                    if (fifo_q.size() > 0) begin
                        cur = fifo_q.pop_front();
                        exp_q.push_back(cur);
                        stage = 1;
                    end
                    nf_cyc   = cyc;
                    mdl_idle = 1'b0;
                end
                chk($sformatf("cfg%0d tx_busy", gi), int'(tx_busy), int'(!mdl_idle));
                if (!in_frame && tx_serial == 1'b0) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("cfg%0d start bit with no byte popped", gi), 1, 0);
                    end else begin
                        fbyte    = exp_q.pop_front();
                        fb       = frame_bits(fbyte, DB, PEN, PODD, SB);
                        in_frame = 1'b1;
                        pos      = 0;
                        bad_pos  = -1;
                        chk($sformatf("cfg%0d pop-to-start cycles", gi), cyc - nf_cyc, 2);
                        if (nf_cyc == end_cyc + 1) begin
                            chk($sformatf("cfg%0d back-to-back mark cycles", gi),
                                cyc - end_cyc - 1, 2);
                        end
                    end
                end
                exp_done = 1'b0;
                if (in_frame) begin
                    if (tx_serial !== 1'((fb >> (pos / CPB)) & 1) && bad_pos < 0) begin
                        bad_pos = pos;
                    end
                    exp_done = (pos == FLEN * CPB - 1);
                    if (exp_done) begin
                        chk($sformatf("cfg%0d byte %02h first wrong clk in frame", gi, fbyte),
                            bad_pos, -1);
                        $display("cfg%0d frame %02h sent, %0d clks, ended cycle %0d",
                                 gi, fbyte, FLEN * CPB, cyc);
                        in_frame = 1'b0;
                        mdl_idle = 1'b1;
                        end_cyc  = cyc;
                    end
                    pos++;
                end
                chk($sformatf("cfg%0d tx_done", gi), int'(tx_done), int'(exp_done));
            end
            prev_rstn  = rst_n;
            tx_enable  = en_req;
            fifo_empty = (fifo_q.size() == 0);
            data_in    = (stage == 2) ? 8'(cur) : 8'($urandom);
            stage      = (stage == 1) ? 2 : 0;
            prev_req   = tx_enable && !fifo_empty;
            cyc++;
        end

        task automatic wait_idle(input int bound);
            int k;
            k = 0;
            while (!(fifo_q.size() == 0 && mdl_idle && !in_frame) && k < bound) begin
                @(posedge clk);
                k++;
            end
            chk($sformatf("cfg%0d drained within bound", gi), int'(k < bound), 1);
            #2;
        endtask

        task automatic wait_frame(input int bound);
            int k;
            k = 0;
            while (!in_frame && k < bound) begin
                @(posedge clk);
                k++;
            end
            chk($sformatf("cfg%0d frame started within bound", gi), int'(k < bound), 1);
            #2;
        endtask

        task automatic check_idle_outputs(input string when);
            chk($sformatf("cfg%0d %s tx_serial", gi, when), int'(tx_serial), 1);
            chk($sformatf("cfg%0d %s next_frame", gi, when), int'(next_frame), 0);
            chk($sformatf("cfg%0d %s tx_busy", gi, when), int'(tx_busy), 0);
            chk($sformatf("cfg%0d %s tx_done", gi, when), int'(tx_done), 0);
        endtask

        // Stimulus: directed frames first, then randomized bursts.
        initial begin
            rst_n  = 1'b0;
            en_req = 1'b0;
            repeat (3) @(posedge clk);
            #2;
            check_idle_outputs("in reset");
            rst_n  = 1'b1;
            en_req = 1'b1;

            fifo_q.push_back(8'hA5);
            wait_idle(2000);
            fifo_q.push_back(8'h07);
            wait_idle(2000);
            fifo_q.push_back(8'hFF);
            wait_idle(2000);
            fifo_q.push_back(8'h55);
            fifo_q.push_back(8'hAA);
            wait_idle(4000);

            // Drop tx_enable during data bit 3. The frame must finish and 8'h81 must stay queued.
            fifo_q.push_back(8'h3C);
            fifo_q.push_back(8'h81);
            wait_frame(500);
            repeat (CPB * 4 + 3) @(posedge clk);
            #2;
            en_req = 1'b0;
            repeat (CPB * FLEN + 50) @(posedge clk);
            #2;
            chk($sformatf("cfg%0d queued bytes after enable drop", gi), fifo_q.size(), 1);
            chk($sformatf("cfg%0d tx_busy after enable drop", gi), int'(tx_busy), 0);
            en_req = 1'b1;
            wait_idle(2000);

            // Reset asserted mid-DATA: the outputs go idle within the same cycle.
            fifo_q.push_back(8'hC3);
            wait_frame(500);
            repeat (CPB * 3) @(posedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            check_idle_outputs("async reset mid-frame");
            repeat (2) @(posedge clk);
            #3;
            rst_n = 1'b1;
            repeat (5) begin
                @(posedge clk);
                #2;
                chk($sformatf("cfg%0d post-reset tx_serial", gi), int'(tx_serial), 1);
                chk($sformatf("cfg%0d post-reset tx_busy", gi), int'(tx_busy), 0);
            end

            for (int k = 0; k < 25; k++) begin
                n_rand = $urandom_range(1, 3);
                for (int j = 0; j < n_rand; j++) begin
                    fifo_q.push_back(8'($urandom));
                end
                if ($urandom_range(0, 3) == 0) begin
                    en_req = 1'b0;
                    repeat ($urandom_range(1, 80)) @(posedge clk);
                    #2;
                    en_req = 1'b1;
                end
                repeat ($urandom_range(0, 200)) @(posedge clk);
                #2;
            end
            wait_idle(20000);
            done_flag = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g[0].done_flag && g[1].done_flag && g[2].done_flag) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 60000) begin
            n_vec++;
            n_err++;
            $display("FAIL overall timeout: got %0d cycles, expected completion before 60000", t);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
